// File: rtl/sme_loader.sv
// sme_loader: upstream feeder for the string-matching engine (SME).
// Collects one job of tagged bytes (string chars, then pattern chars) over a
// valid/ready handshake, replays it to the SME as a contiguous isstring burst
// followed by a contiguous ispattern burst, then waits for sme_valid (or a
// timeout) before accepting the next job.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   in_data/kind/last     input beat: byte, 0=string 1=pattern, end of job
//   in_valid/in_ready     input handshake (ready is registered)
//   chardata              character to SME (registered)
//   isstring/ispattern    SME strobes (registered, mutually exclusive)
//   sme_valid             SME result strobe
//   busy                  high whenever not collecting
//   err                   sticky job error, cleared by the next job's first beat
//   timeout               one-cycle pulse when the SME never answered
//   jobs_done             jobs closed by sme_valid (wraps)
module sme_loader #(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8,
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_kind,
   input  logic       in_last,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] chardata,
   output logic       isstring,
   output logic       ispattern,
   input  logic       sme_valid,
   output logic       busy,
   output logic       err,
   output logic       timeout,
   output logic [7:0] jobs_done
);
   localparam int SW  = $clog2(STR_MAX + 1);
   localparam int PW  = $clog2(PAT_MAX + 1);
   localparam int IW  = $clog2(STR_MAX);
   localparam int PIW = $clog2(PAT_MAX);
   localparam logic [SW-1:0] STR_FULL  = SW'(STR_MAX);
   localparam logic [PW-1:0] PAT_FULL  = PW'(PAT_MAX);
   localparam logic [7:0]    WAIT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {COLLECT, SEND_STR, SEND_PAT, WAIT_RES} state_t;

   state_t                    state;
   logic [STR_MAX-1:0][7:0]   str_buf;
   logic [PAT_MAX-1:0][7:0]   pat_buf;
   logic [SW-1:0]             str_cnt;
   logic [PW-1:0]             pat_cnt;
   logic [IW-1:0]             idx;
   logic [7:0]                wait_cnt;
   logic                      fresh;     // no beat of the current job seen yet

   logic          beat, str_ok, pat_ok, beat_bad, close;
   logic [SW-1:0] str_cnt_n;
   logic [PW-1:0] pat_cnt_n;
   logic [IW-1:0] idx_n;
   logic          str_last, pat_last;
   logic [7:0]    pat_first;

   always_comb begin
      beat      = in_valid & in_ready & (state == COLLECT);
      // string chars are only legal before the first pattern char
      str_ok    = beat & ~in_kind & (pat_cnt == '0) & (str_cnt != STR_FULL);
      pat_ok    = beat & in_kind & (pat_cnt != PAT_FULL);
      beat_bad  = beat & ~(str_ok | pat_ok);
      close     = beat & in_last;
      str_cnt_n = str_cnt + SW'(str_ok);
      pat_cnt_n = pat_cnt + PW'(pat_ok);
      idx_n     = idx + IW'(1);
      str_last  = (SW'(idx) == str_cnt - SW'(1));
      pat_last  = (PW'(idx) == pat_cnt - PW'(1));
      // a pattern-only job may be closed by its very first pattern char,
      // which is still on in_data rather than in the buffer
      pat_first = (pat_cnt == '0) ? in_data : pat_buf[0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= COLLECT;
         str_buf   <= '0;
         pat_buf   <= '0;
         str_cnt   <= '0;
         pat_cnt   <= '0;
         idx       <= '0;
         wait_cnt  <= '0;
         fresh     <= 1'b1;
         in_ready  <= 1'b0;
         chardata  <= '0;
         isstring  <= 1'b0;
         ispattern <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
         timeout   <= 1'b0;
         jobs_done <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            COLLECT: begin
               in_ready <= 1'b1;
               if (beat) begin
                  fresh   <= 1'b0;
                  err     <= (err & ~fresh) | beat_bad;
                  str_cnt <= str_cnt_n;
                  pat_cnt <= pat_cnt_n;
                  if (str_ok) str_buf[str_cnt[IW-1:0]] <= in_data;
                  if (pat_ok) pat_buf[pat_cnt[PIW-1:0]] <= in_data;
                  if (close) begin
                     fresh <= 1'b1;
                     if (pat_cnt_n == '0) begin
                        // nothing to match against: drop the job in place
                        err     <= 1'b1;
                        str_cnt <= '0;
                        pat_cnt <= '0;
                     end else begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        idx      <= '0;
                        if (str_cnt_n != '0) begin
                           state    <= SEND_STR;
                           isstring <= 1'b1;
                           chardata <= str_buf[0];
                        end else begin
                           state     <= SEND_PAT;
                           ispattern <= 1'b1;
                           chardata  <= pat_first;
                        end
                     end
                  end
               end
            end
            SEND_STR: begin
               if (str_last) begin
                  state     <= SEND_PAT;
                  isstring  <= 1'b0;
                  ispattern <= 1'b1;
                  idx       <= '0;
                  chardata  <= pat_buf[0];
               end else begin
                  idx      <= idx_n;
                  chardata <= str_buf[idx_n];
               end
            end
            SEND_PAT: begin
               if (pat_last) begin
                  state     <= WAIT_RES;
                  ispattern <= 1'b0;
                  wait_cnt  <= '0;
               end else begin
                  idx      <= idx_n;
                  chardata <= pat_buf[idx_n[PIW-1:0]];
               end
            end
            WAIT_RES: begin
               // sme_valid has priority over an expiring timer
               if (sme_valid || wait_cnt == WAIT_LAST) begin
                  state    <= COLLECT;
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
                  str_cnt  <= '0;
                  pat_cnt  <= '0;
                  if (sme_valid) begin
                     jobs_done <= jobs_done + 8'd1;
                  end else begin
                     timeout <= 1'b1;
                     err     <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end
endmodule

// File: tb/tb_sme_loader.sv
// Randomized bench for sme_loader. A queue-based model derives, from the
// job's beat list, which chars must come out of each burst and whether the
// job is erroneous or dropped; outputs are sampled on the falling edge.
module tb_sme_loader;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_kind = 1'b0, in_last = 1'b0, in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] chardata;
   logic       isstring, ispattern;
   logic       sme_valid = 1'b0;
   logic       busy, err, timeout;
   logic [7:0] jobs_done;

   always #5 clk = ~clk;

   sme_loader dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_kind(in_kind),
      .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
      .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
      .sme_valid(sme_valid), .busy(busy), .err(err), .timeout(timeout),
      .jobs_done(jobs_done)
   );

   int          n_vec = 0, n_bad = 0;
   byte unsigned bd[$];      // job beats: data
   bit          bk[$];       // job beats: kind
   byte unsigned sq[$], pq[$];
   bit          m_err;
   int          m_jobs = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic add(input bit k, input byte unsigned d);
      bd.push_back(d);
      bk.push_back(k);
   endtask

   task automatic add_s(input bit k, input string s);
      for (int i = 0; i < s.len(); i++) add(k, s[i]);
   endtask

   // Drive the job's beats with random gaps (and stray sme_valid pulses,
   // which must be ignored while collecting); model the buffering rules.
   task automatic drive_job(output bit dropped);
      int g, t;
      sq.delete(); pq.delete(); m_err = 1'b0;
      for (int i = 0; i < bd.size(); i++) begin
         g = $urandom_range(0, 2);
         repeat (g) begin
            in_valid = 1'b0;
            in_data = 8'($urandom);
            sme_valid = ($urandom_range(0, 3) == 0);
            @(negedge clk);
         end
         sme_valid = 1'b0;
         in_valid = 1'b1; in_data = bd[i]; in_kind = bk[i];
         in_last = (i == bd.size() - 1);
         t = 0;
         while (!in_ready && t < 20) begin @(negedge clk); t++; end
         chk("ready_wait", 32'(t < 20), 32'd1);
         if (bk[i] == 1'b0) begin
            if (pq.size() > 0 || sq.size() == 32) m_err = 1'b1;
            else sq.push_back(bd[i]);
         end else begin
            if (pq.size() == 8) m_err = 1'b1;
            else pq.push_back(bd[i]);
         end
         @(negedge clk);
         in_valid = 1'b0; in_last = 1'b0;
         if (i != bd.size() - 1)
            chk("err_run", 32'({in_ready, err, busy}), 32'({1'b1, m_err, 1'b0}));
      end
      dropped = (pq.size() == 0);
      if (dropped) m_err = 1'b1;
   endtask

   task automatic check_bursts();
      chk("err_job", 32'(err), 32'(m_err));
      foreach (sq[k]) begin
         chk("str_beat", 32'({isstring, ispattern, in_ready, busy, chardata}), 32'({4'b1001, sq[k]}));
         @(negedge clk);
      end
      foreach (pq[k]) begin
         chk("pat_beat", 32'({isstring, ispattern, in_ready, busy, chardata}), 32'({4'b0101, pq[k]}));
         @(negedge clk);
      end
      chk("burst_end", 32'({isstring, ispattern, in_ready, busy, chardata}), 32'({4'b0001, pq[pq.size()-1]}));
   endtask

   // lat >= 0: SME answers lat cycles after WAIT_RES entry; lat < 0: never.
   task automatic finish_job(input int lat);
      int c;
      if (lat >= 0) begin
         for (int i = 0; i < lat; i++) begin
            chk("wait", 32'({isstring, ispattern, in_ready, busy, timeout}), 32'(5'b00010));
            @(negedge clk);
         end
         sme_valid = 1'b1;
         @(negedge clk);
         sme_valid = 1'b0;
         m_jobs++;
         chk("done", 32'({jobs_done, in_ready, busy, timeout}), 32'({8'(m_jobs), 3'b100}));
      end else begin
         c = 0;
         while (!timeout && c < 300) begin @(negedge clk); c++; end
         chk("to_cycles", 32'(c), 32'd255);
         chk("to_flags", 32'({err, in_ready, busy}), 32'(3'b110));
         @(negedge clk);
         chk("to_after", 32'({timeout, in_ready, jobs_done}), 32'({2'b01, 8'(m_jobs)}));
      end
   endtask

   task automatic run_job(input int lat);
      bit dr;
      drive_job(dr);
      if (dr) chk("drop", 32'({isstring, ispattern, in_ready, busy, err}), 32'(5'b00101));
      else begin
         check_bursts();
         finish_job(lat);
      end
      bd.delete(); bk.delete();
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, got hang want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ns, np, pos, lat;
      bit dr;
      @(negedge clk);
      chk("rst_vals", 32'({in_ready, chardata, isstring, ispattern, busy, err, timeout, jobs_done}), 32'd0);
      reset = 1'b1;
      chk("rst_rel", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("ready_up", 32'(in_ready), 32'd1);

      // "ab c" / "^c"
      add_s(0, "ab c"); add_s(1, "^c"); run_job(2);
      // pattern-only ".*"
      add_s(1, ".*"); run_job(0);
      // 34 string chars + 1 pattern char: overflow
      for (int i = 0; i < 34; i++) add(0, 8'(8'h40 + i));
      add(1, 8'h21); run_job(3);
      // x, y (misordered), z
      add(1, "x"); add(0, "y"); add(1, "z"); run_job(1);
      // SME never answers
      add_s(0, "abc"); add_s(1, "b"); run_job(-1);
      // sme_valid in the same cycle the timer would expire
      add_s(0, "q"); add_s(1, "qq"); run_job(254);
      // job without any pattern char is dropped
      add_s(0, "zz"); run_job(0);

      // reset during the 3rd isstring cycle
      add_s(0, "abcdef"); add_s(1, "p");
      drive_job(dr);
      @(negedge clk); @(negedge clk);
      chk("pre_rst", 32'({isstring, chardata}), 32'({1'b1, 8'h63}));
      #1 reset = 1'b0;
      #1 chk("rst_async", 32'({in_ready, chardata, isstring, ispattern, busy, err, timeout, jobs_done}), 32'd0);
      bd.delete(); bk.delete(); m_jobs = 0;
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'({in_ready, busy}), 32'(2'b10));
      add_s(0, "hello"); add_s(1, "l*o"); run_job(4);

      // randomized jobs
      for (int j = 0; j < 40; j++) begin
         ns = $urandom_range(0, 35);
         np = $urandom_range(0, 10);
         for (int i = 0; i < ns; i++) add(0, 8'($urandom));
         for (int i = 0; i < np; i++) add(1, 8'($urandom));
         if (np > 0 && $urandom_range(0, 4) == 0) begin
            pos = ns + $urandom_range(1, np);
            bd.insert(pos, 8'($urandom));
            bk.insert(pos, 1'b0);
         end
         if (bd.size() == 0) add(0, 8'($urandom));
         lat = ($urandom_range(0, 14) == 0) ? -1 : $urandom_range(0, 6);
         run_job(lat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/sme_loader.md
Name: sme_loader

Overview:
- Upstream feeder for the string-matching engine (SME).
- Accepts one tagged byte stream per job through a valid/ready handshake and buffers one job: up to 32 string chars and up to 8 pattern chars.
- Replays the job to the SME as one contiguous isstring burst, then one contiguous ispattern burst.
- Holds the SME inputs idle until the SME reports valid, then accepts the next job.

Parameters:
STR_MAX, 32, maximum buffered string characters per job (index width 5, count width 6)
PAT_MAX, 8, maximum buffered pattern characters per job (count width 4)
TIMEOUT, 255, cycles waited for sme_valid before abandoning the job (8-bit counter)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
in_data  input  8  character byte
in_kind  input  1  0 = string char, 1 = pattern char
in_last  input  1  marks the final beat of a job
in_valid  input  1  beat offered
in_ready  output  1  beat accepted when in_valid && in_ready
chardata  output  8  character to SME (registered)
isstring  output  1  string character strobe to SME (registered)
ispattern  output  1  pattern character strobe to SME (registered)
sme_valid  input  1  SME result strobe, one cycle
busy  output  1  high in every state except COLLECT
err  output  1  sticky job error (overflow, ordering or timeout); cleared on first beat of the next job
timeout  output  1  one-cycle pulse when TIMEOUT expires
jobs_done  output  8  count of jobs closed by sme_valid; wraps 255 -> 0

Behaviour:
- Reset values: in_ready=0, chardata=0, isstring=0, ispattern=0, busy=0, err=0, timeout=0, jobs_done=0. State is COLLECT; counts and buffers are 0. in_ready rises in the first cycle after reset releases.
- Reset mid-operation: immediate return to reset values. A partially sent job is dropped; no strobes remain asserted.
- COLLECT: in_ready=1.
  - String beat: stored at str_buf[str_cnt], str_cnt++.
  - Pattern beat: stored at pat_buf[pat_cnt], pat_cnt++.
  - Once str_cnt=STR_MAX or pat_cnt=PAT_MAX, further beats of that kind are discarded and err is set.
  - A string beat arriving after any pattern beat in the same job is discarded and err is set.
  - A beat with in_last=1 closes the job; the beat itself is stored under the same rules.
  - On close with pat_cnt=0: the job is dropped, err is set, and the block stays in COLLECT with counts cleared.
  - Otherwise, with str_cnt>0: next state SEND_STR. With str_cnt=0: next state SEND_PAT; the SME reuses its previous string.
- SEND_STR: in_ready=0.
  - Each cycle drives isstring=1 and chardata=str_buf[idx]; idx runs 0..str_cnt-1 on consecutive cycles with no gaps.
  - The first strobe appears in the cycle after the closing beat is accepted.
  - After the last char: SEND_PAT, with no idle cycle between the bursts.
- SEND_PAT: ispattern=1, chardata=pat_buf[idx] for idx 0..pat_cnt-1, back-to-back. Then WAIT_RES, with isstring=ispattern=0 and chardata held.
- isstring and ispattern are never high in the same cycle.
- WAIT_RES: strobes low. A wait counter starts at 0 and increments each cycle.
  - sme_valid=1: jobs_done++, counts cleared, next state COLLECT.
  - Counter reaches TIMEOUT: timeout pulses one cycle, err is set, counts cleared, next state COLLECT.
  - Both in the same cycle: sme_valid wins and no timeout pulse is issued.
  - sme_valid arriving in any other state is ignored.
- Throughput: one job in flight. Minimum job period = beats + str_cnt + pat_cnt + SME latency + 1.

Test Plan:
- String "ab c" (4 beats, kind 0) then pattern "^c" (2 beats, last on 'c') -> isstring high 4 consecutive cycles with 61,62,20,63; ispattern 2 cycles with 5E,63; in_ready=0 until sme_valid; jobs_done 0->1.
- Pattern-only job ".*" -> no isstring; ispattern 2 cycles with 2E,2A; err=0.
- 34 string beats + 1 pattern beat -> exactly 32 isstring strobes (the first 32 chars); err=1 after the 33rd beat; job still sent.
- Pattern beat 'x' then string beat 'y' then last pattern beat 'z' -> 'y' dropped; no isstring; ispattern 2 cycles x,z; err=1.
- SME never asserts valid, TIMEOUT=255 -> timeout pulse exactly 255 cycles after WAIT_RES entry; err=1; in_ready=1 the next cycle.
- Reset asserted low during the 3rd isstring cycle -> all outputs 0 asynchronously; after release, a fresh job sends its full bursts correctly.
